// File: rtl/sysbus_arbiter_pkg.sv
// rtl/sysbus_arbiter_pkg.sv - shared encodings for the two-port system bus arbiter
package sysbus_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_STROBE,
      ST_XFER,
      ST_LAST,
      ST_DONE
   } state_t;

   localparam logic READ   = 1'b1;
   localparam logic WRITE  = 1'b0;
   localparam int   NPORTS = 2;

   function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
      return 8'(w >> {idx, 3'b000});
   endfunction

endpackage

// File: rtl/sysbus_arbiter_rr_pick.sv
// rtl/sysbus_arbiter_rr_pick.sv - round-robin winner select for two requesters
module rr_pick (
   input  logic [1:0] req,
   input  logic       last,
   output logic       winner,
   output logic       valid
);

   // A tie goes to the port that was not served last; a lone request wins outright.
   always_comb begin
      valid  = |req;
      winner = (&req) ? ~last : req[1];
   end

endmodule

// File: rtl/sysbus_arbiter.sv
// rtl/sysbus_arbiter.sv - two-port word bus to byte-wide system memory arbiter
module sysbus_arbiter
   import sysbus_arbiter_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0,
   input  logic        rw0,
   input  logic [13:0] addr0,
   input  logic [31:0] wdata0,
   output logic [31:0] rdata0,
   output logic        ack0,
   input  logic        req1,
   input  logic        rw1,
   input  logic [13:0] addr1,
   input  logic [31:0] wdata1,
   output logic [31:0] rdata1,
   output logic        ack1,
   output logic [15:0] mem_address,
   output logic [7:0]  mem_data_out,
   input  logic [7:0]  mem_data_in,
   output logic        mem_rw,
   output logic        mem_strobe,
   output logic        busy,
   output logic        grant_id
);

   state_t            state, state_n;
   logic [1:0]        cnt, cnt_n;
   logic              lat_rw, rw_n;
   logic [13:0]       lat_addr, addr_n;
   logic [31:0]       lat_wdata, wdata_n;
   logic              gid_n;
   logic              last_grant;
   logic [23:0]       rbuf;
   logic [NPORTS-1:0] req_vec;
   logic              pick, pick_valid;

   assign req_vec = {req1, req0};

   rr_pick u_pick (
      .req    (req_vec),
      .last   (last_grant),
      .winner (pick),
      .valid  (pick_valid)
   );

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      rw_n    = lat_rw;
      addr_n  = lat_addr;
      wdata_n = lat_wdata;
      gid_n   = grant_id;
      case (state)
         ST_IDLE: begin
            if (pick_valid) begin
               state_n = ST_STROBE;
               cnt_n   = 2'd0;
               gid_n   = pick;
               rw_n    = pick ? rw1    : rw0;
               addr_n  = pick ? addr1  : addr0;
               wdata_n = pick ? wdata1 : wdata0;
            end
         end
         ST_STROBE: begin
            state_n = ST_XFER;
            cnt_n   = 2'd0;
         end
         ST_XFER: begin
            if (cnt == 2'd3) state_n = ST_LAST;
            else             cnt_n   = cnt + 2'd1;
         end
         ST_LAST: state_n = ST_DONE;
         ST_DONE: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   // Outputs are flops loaded from the next-state view so they line up with the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         cnt          <= 2'd0;
         lat_rw       <= 1'b0;
         lat_addr     <= '0;
         lat_wdata    <= '0;
         last_grant   <= 1'b1;
         rbuf         <= '0;
         rdata0       <= '0;
         rdata1       <= '0;
         ack0         <= 1'b0;
         ack1         <= 1'b0;
         mem_address  <= '0;
         mem_data_out <= '0;
         mem_rw       <= 1'b0;
         mem_strobe   <= 1'b0;
         busy         <= 1'b0;
         grant_id     <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         lat_rw     <= rw_n;
         lat_addr   <= addr_n;
         lat_wdata  <= wdata_n;
         grant_id   <= gid_n;
         mem_strobe <= (state_n == ST_STROBE);
         busy       <= (state_n != ST_IDLE);
         ack0       <= (state_n == ST_DONE) && !gid_n;
         ack1       <= (state_n == ST_DONE) &&  gid_n;

         if (state_n == ST_STROBE || state_n == ST_XFER) begin
            mem_address  <= {addr_n, cnt_n};
            mem_rw       <= rw_n;
            mem_data_out <= (rw_n == WRITE) ? word_byte(wdata_n, cnt_n) : 8'h00;
         end else begin
            mem_data_out <= 8'h00;
         end

         // Read data lags its address by one cycle, so byte cnt-1 arrives while cnt is presented.
         if (state == ST_XFER && lat_rw == READ) begin
            case (cnt)
               2'd1:    rbuf[7:0]   <= mem_data_in;
               2'd2:    rbuf[15:8]  <= mem_data_in;
               2'd3:    rbuf[23:16] <= mem_data_in;
               default: ;
            endcase
         end

         if (state == ST_LAST && lat_rw == READ) begin
            if (grant_id) rdata1 <= {mem_data_in, rbuf};
            else          rdata0 <= {mem_data_in, rbuf};
         end

         if (state == ST_DONE) last_grant <= grant_id;
      end
   end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// tb/tb_sysbus_arbiter.sv - self-checking bench for sysbus_arbiter
module tb_sysbus_arbiter;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        req   [2];
   logic        rw    [2];
   logic [13:0] addr  [2];
   logic [31:0] wdata [2];
   logic [31:0] rdata0, rdata1;
   logic        ack0, ack1;
   logic [15:0] mem_address;
   logic [7:0]  mem_data_out;
   logic [7:0]  mem_data_in = 8'h00;
   logic        mem_rw, mem_strobe, busy, grant_id;

   sysbus_arbiter dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req0         (req[0]),
      .rw0          (rw[0]),
      .addr0        (addr[0]),
      .wdata0       (wdata[0]),
      .rdata0       (rdata0),
      .ack0         (ack0),
      .req1         (req[1]),
      .rw1          (rw[1]),
      .addr1        (addr[1]),
      .wdata1       (wdata[1]),
      .rdata1       (rdata1),
      .ack1         (ack1),
      .mem_address  (mem_address),
      .mem_data_out (mem_data_out),
      .mem_data_in  (mem_data_in),
      .mem_rw       (mem_rw),
      .mem_strobe   (mem_strobe),
      .busy         (busy),
      .grant_id     (grant_id)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory content is a fixed function of byte address; 0x40..0x43 hold 11,22,33,44.
   function automatic logic [7:0] mem_byte(input logic [15:0] a);
      logic [7:0] lane;
      lane = {6'b0, a[1:0]} + 8'd1;
      return 8'(lane * 8'h11) ^ a[9:2] ^ 8'h10;
   endfunction

   function automatic logic [31:0] rd_word(input logic [13:0] a);
      return {mem_byte({a, 2'd3}), mem_byte({a, 2'd2}), mem_byte({a, 2'd1}), mem_byte({a, 2'd0})};
   endfunction

   logic [15:0] prev_addr = '0;
   always @(negedge clk) begin
      mem_data_in = mem_byte(prev_addr);
      prev_addr   = mem_address;
   end

   // Transaction-level model: a grant at edge e owns the bus for edges e..e+7.
   int          edge_n = 0;
   bit          m_active, m_port, m_rw, m_last, m_gid;
   int          m_e;
   logic [13:0] m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata [2];
   bit          m_ack [2];
   int          grants = 0, completes = 0, dut_strobes = 0, dut_acks = 0;
   int          done_port [2];
   int          wait_cnt [2];
   int          max_wait [2];

   task automatic model_reset();
      m_active = 0; m_gid = 0; m_last = 1;
      for (int p = 0; p < 2; p++) begin
         m_rdata[p] = '0; m_ack[p] = 0; wait_cnt[p] = 0;
      end
   endtask

   task automatic model_edge();
      int j;
      bit port;
      edge_n++;
      m_ack[0] = 0; m_ack[1] = 0;
      if (m_active) begin
         j = edge_n - m_e;
         if (j == 6) begin
            m_ack[m_port] = 1;
            if (m_rw) m_rdata[m_port] = rd_word(m_addr);
            m_last = m_port;
            completes++;
            done_port[m_port]++;
         end
         if (j == 7) m_active = 0;
      end else if (req[0] || req[1]) begin
         port     = (req[0] && req[1]) ? !m_last : req[1];
         m_port   = port;
         m_gid    = port;
         m_rw     = rw[port];
         m_addr   = addr[port];
         m_wdata  = wdata[port];
         m_e      = edge_n;
         m_active = 1;
         grants++;
      end
      for (int p = 0; p < 2; p++) begin
         if (req[p] && !(m_active && m_port == 1'(p))) wait_cnt[p]++;
         else wait_cnt[p] = 0;
         if (wait_cnt[p] > max_wait[p]) max_wait[p] = wait_cnt[p];
      end
   endtask

   task automatic compare();
      int         j;
      logic [1:0] bi;
      logic [7:0] ed;
      j = m_active ? edge_n - m_e : 99;
      chk("busy", busy, m_active);
      chk("mem_strobe", mem_strobe, m_active && j == 0);
      chk("ack0", ack0, m_ack[0]);
      chk("ack1", ack1, m_ack[1]);
      chk("grant_id", grant_id, m_gid);
      chk("rdata0", rdata0, m_rdata[0]);
      chk("rdata1", rdata1, m_rdata[1]);
      ed = 8'h00;
      if (m_active && j <= 4) begin
         bi = (j == 0) ? 2'd0 : 2'(j - 1);
         chk("mem_address", mem_address, {m_addr, bi});
         chk("mem_rw", mem_rw, m_rw);
         if (!m_rw) ed = 8'(m_wdata >> (8 * bi));
      end
      chk("mem_data_out", mem_data_out, ed);
      if (mem_strobe) dut_strobes++;
      if (ack0) dut_acks++;
      if (ack1) dut_acks++;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      compare();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_ack", {ack1, ack0}, 0);
      chk("rst_strobe", mem_strobe, 0);
      chk("rst_addr", mem_address, 0);
      chk("rst_dout", mem_data_out, 0);
      chk("rst_rw", mem_rw, 0);
      chk("rst_rdata0", rdata0, 0);
      chk("rst_rdata1", rdata1, 0);
      chk("rst_gid", grant_id, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   logic [15:0] addr_log [32];
   logic [7:0]  dout_log [32];
   logic        rw_log   [32];

   task automatic wait_ack(input int p, input int max, input bit scramble, output int k);
      bit hit;
      k = 0; hit = 0;
      while (!hit && k < max) begin
         tick();
         k++;
         if (k < 32) begin
            addr_log[k] = mem_address; dout_log[k] = mem_data_out; rw_log[k] = mem_rw;
         end
         if (k == 1 && scramble) begin
            rw[p] = ~rw[p]; addr[p] = ~addr[p]; wdata[p] = ~wdata[p];
         end
         if ((p == 0) ? ack0 : ack1) hit = 1;
      end
      if (!hit) chk("ack_timeout", 0, 1);
   endtask

   task automatic drive_random();
      for (int p = 0; p < 2; p++) begin
         if (m_ack[p]) begin
            req[p] = 1'b0;
         end else if (!req[p]) begin
            if ($urandom_range(2) == 0) begin
               req[p] = 1'b1; rw[p] = 1'($urandom_range(1));
               addr[p] = 14'($urandom); wdata[p] = $urandom;
            end
         end else begin
            if ($urandom_range(3) == 0) begin
               rw[p] = 1'($urandom_range(1)); addr[p] = 14'($urandom); wdata[p] = $urandom;
            end
            if ($urandom_range(49) == 0) req[p] = 1'b0;
         end
      end
   endtask

   initial begin
      int k, n_ack, n_str, cyc, bg, bc, bs, ba;
      for (int p = 0; p < 2; p++) begin
         req[p] = 0; rw[p] = 0; addr[p] = '0; wdata[p] = '0;
         done_port[p] = 0; max_wait[p] = 0;
      end
      #1;
      do_reset();
      tick();

      // single read on port 0
      req[0] = 1; rw[0] = 1; addr[0] = 14'h0010;
      wait_ack(0, 20, 0, k);
      chk("read_latency", k, 7);
      chk("read_addr_strobe", addr_log[1], 16'h0040);
      chk("read_addr_b1", addr_log[3], 16'h0041);
      chk("read_addr_b3", addr_log[5], 16'h0043);
      chk("read_rdata0", rdata0, 32'h44332211);
      req[0] = 0;
      tick();

      // single write on port 1, inputs scrambled right after grant
      req[1] = 1; rw[1] = 0; addr[1] = 14'h0001; wdata[1] = 32'hDEADBEEF;
      wait_ack(1, 20, 1, k);
      chk("write_latency", k, 7);
      chk("write_rw", rw_log[1], 0);
      chk("write_b0", {addr_log[2], dout_log[2]}, {16'h0004, 8'hEF});
      chk("write_b1", {addr_log[3], dout_log[3]}, {16'h0005, 8'hBE});
      chk("write_b2", {addr_log[4], dout_log[4]}, {16'h0006, 8'hAD});
      chk("write_b3", {addr_log[5], dout_log[5]}, {16'h0007, 8'hDE});
      chk("write_rdata1", rdata1, 32'h0);
      chk("write_rdata0_kept", rdata0, 32'h44332211);
      req[1] = 0;
      tick();

      // request dropped mid-transfer still completes exactly once
      req[0] = 1; rw[0] = 0; addr[0] = 14'h0123; wdata[0] = $urandom;
      n_ack = 0; n_str = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (i == 2) req[0] = 0;
         if (ack0) n_ack++;
         if (mem_strobe) n_str++;
      end
      chk("abandon_acks", n_ack, 1);
      chk("abandon_strobes", n_str, 1);

      // tie after reset alternates 0, 1, 0
      do_reset();
      req[0] = 1; rw[0] = 1; addr[0] = 14'h0200;
      req[1] = 1; rw[1] = 0; addr[1] = 14'h0300; wdata[1] = 32'h01020304;
      wait_ack(0, 20, 0, k);
      chk("tie_first_port0", k, 7);
      wait_ack(1, 20, 0, k);
      chk("tie_then_port1", k, 8);
      wait_ack(0, 20, 0, k);
      chk("tie_repeat_port0", k, 8);
      req[0] = 0; req[1] = 0;
      repeat (10) tick();

      // reset in the middle of a transfer, then a fresh port 1 request
      req[0] = 1; rw[0] = 0; addr[0] = 14'h0055; wdata[0] = 32'hCAFEF00D;
      repeat (3) tick();
      req[0] = 0; req[1] = 1; rw[1] = 1; addr[1] = 14'h0ABC;
      do_reset();
      tick();
      chk("post_reset_strobe", mem_strobe, 1);
      chk("post_reset_gid", grant_id, 1);
      wait_ack(1, 20, 0, k);
      chk("post_reset_latency", k, 6);
      req[1] = 0;
      tick();

      // randomized stress
      bg = grants; bc = completes; bs = dut_strobes; ba = dut_acks;
      done_port[0] = 0; done_port[1] = 0; max_wait[0] = 0; max_wait[1] = 0;
      cyc = 0;
      while ((completes - bc) < 1000 && cyc < 30000) begin
         drive_random();
         tick();
         cyc++;
      end
      chk("stress_budget", ((completes - bc) >= 1000), 1);
      req[0] = 0; req[1] = 0;
      repeat (10) tick();
      chk("stress_acks", dut_acks - ba, completes - bc);
      chk("stress_strobes", dut_strobes - bs, grants - bg);
      chk("stress_served0", done_port[0] > 0, 1);
      chk("stress_served1", done_port[1] > 0, 1);
      // a port waits at most through one other transaction (plus the DONE->IDLE edge)
      chk("stress_wait0", max_wait[0] <= 9, 1);
      chk("stress_wait1", max_wait[1] <= 9, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sysbus_arbiter.md
SYSBUS_ARBITER -- requirements
Module: sysbus_arbiter

Interface
REQ-001 Clock and reset SHALL be: one clock; reset is asynchronous and active-low. Port names are clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 reqN (N=0,1)  input  1  level request, held by requester N until ackN.
REQ-005 rwN  input  1  1=read, 0=write; sampled with reqN at grant.
REQ-006 addrN  input  14  word address; sampled at grant.
REQ-007 wdataN  input  32  write word; sampled at grant.
REQ-008 rdataN  output  32  read word returned to requester N.
REQ-009 ackN  output  1  one-cycle completion pulse to requester N.
REQ-010 mem_address  output  16  byte address to system memory, {word address, byte index}.
REQ-011 mem_data_out  output  8  write byte to memory.
REQ-012 mem_data_in  input  8  read byte; valid the cycle after its address is presented.
REQ-013 mem_rw  output  1  1=read, 0=write.
REQ-014 mem_strobe  output  1  one-cycle transaction start.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 grant_id  output  1  index of the requester being served or last served.

Function
REQ-017 All outputs SHALL be registered.
REQ-018 FSM states: IDLE, STROBE, XFER, LAST, DONE; 2-bit byte counter cnt.
REQ-019 IDLE: if any reqN is high, select a winner, latch its rw/addr/wdata, set grant_id, go to STROBE; otherwise stay.
REQ-020 Arbitration SHALL be round-robin: if both requests are high, grant the port not granted last; a single request is granted immediately.
REQ-021 STROBE: mem_strobe=1, mem_rw=latched rw, mem_address={addr,2'b00}; cnt=0; go to XFER.
REQ-022 XFER: mem_address={addr,cnt}; on writes mem_data_out=wdata byte cnt (bits 8cnt+7:8cnt); on reads capture mem_data_in into byte cnt-1 when cnt>0; after cnt=3, go to LAST.
REQ-023 LAST: on reads capture mem_data_in into byte 3; go to DONE.
REQ-024 DONE: pulse ack of the granted port for exactly one cycle; on reads rdataN is valid from that cycle on; update the last-grant record; go to IDLE.
REQ-025 Latency: with a request sampled in IDLE at cycle T, ack SHALL be high in cycle T+7; back-to-back service SHALL resume at T+8.
REQ-026 mem_data_out SHALL be 0 on reads; mem_strobe SHALL be 0 outside STROBE.
REQ-027 rdataN SHALL hold its value until the next completed read for port N; a write SHALL NOT modify rdataN.
REQ-028 Deasserting reqN mid-transaction SHALL NOT abort it; the transaction completes and ack still pulses.
REQ-029 Changing rwN, addrN or wdataN after grant SHALL have no effect on the current transaction.
REQ-030 The non-granted request SHALL wait and be served next; no port waits more than one transaction.

Reset
REQ-031 On rst_n low, asynchronously: state=IDLE, cnt=0, all outputs 0 (rdataN=0, ackN=0, mem_*=0, busy=0, grant_id=0), last-grant=1 (port 0 wins the first tie).
REQ-032 Reset mid-transaction SHALL abandon it without ack; the first edge after release SHALL be evaluated in IDLE.

Structure
REQ-033 Shared package SHALL hold the state encoding, the READ=1/WRITE=0 constants and the port-count constant.
REQ-034 A combinational sub-module rr_pick (two requests plus last-grant in, winner plus valid out) SHALL implement the arbitration; everything else stays in sysbus_arbiter.

Verification
REQ-035 Single read: req0=1, rw0=1, addr0=14'h0010, memory returns bytes 11,22,33,44 -> mem_address 0x0040..0x0043, ack0 at T+7, rdata0=32'h44332211.
REQ-036 Single write: req1=1, rw1=0, addr1=14'h0001, wdata1=32'hDEADBEEF -> mem_rw=0, mem_data_out EF,BE,AD,DE on addresses 0x0004..0x0007, ack1 at T+7, rdata1 unchanged.
REQ-037 Tie after reset: req0=req1=1 -> port 0 served first (ack0), then port 1 (ack1 eight cycles later); a repeated tie is then granted to port 0.
REQ-038 Abandon: drop req0 during XFER -> transaction completes, ack0 pulses once, no new strobe follows.
REQ-039 Reset mid-XFER -> all outputs 0 immediately, no ack; a new req1 after release gives mem_strobe in the second cycle.
REQ-040 Stress: random requests for 1000 transactions -> exactly one ack per grant, mem_strobe count equals ack count, and no port starved.
